// File: rtl/affine_sb_mv_gen.sv
`timescale 1ns/1ps
// Affine sub-block MV generator: walks a CU's sub-blocks in raster order and emits
// rounded, clipped 1/16-pel MVs derived from 4- or 6-parameter control-point MVs.
module affine_sb_mv_gen #(
    parameter int unsigned MV_W     = 16,
    parameter int unsigned OUT_W    = 18,
    parameter int unsigned MAX_LOG2 = 7,
    parameter int unsigned SB_LOG2  = 2
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              start,
    input  logic                              mode_6param,
    input  logic [2:0]                        log2_w,
    input  logic [2:0]                        log2_h,
    input  logic signed [MV_W-1:0]            cpmv0_x,
    input  logic signed [MV_W-1:0]            cpmv0_y,
    input  logic signed [MV_W-1:0]            cpmv1_x,
    input  logic signed [MV_W-1:0]            cpmv1_y,
    input  logic signed [MV_W-1:0]            cpmv2_x,
    input  logic signed [MV_W-1:0]            cpmv2_y,
    input  logic                              out_ready,
    output logic                              out_valid,
    output logic signed [OUT_W-1:0]           out_mv_x,
    output logic signed [OUT_W-1:0]           out_mv_y,
    output logic signed [OUT_W-5:0]           out_mv_x_int,
    output logic signed [OUT_W-5:0]           out_mv_y_int,
    output logic [3:0]                        out_mv_x_frac,
    output logic [3:0]                        out_mv_y_frac,
    output logic [MAX_LOG2-SB_LOG2-1:0]       out_sb_x,
    output logic [MAX_LOG2-SB_LOG2-1:0]       out_sb_y,
    output logic                              out_last,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    localparam int unsigned ACC_W = MV_W + MAX_LOG2 + 8;
    localparam int unsigned IDX_W = MAX_LOG2 - SB_LOG2;
    localparam int unsigned INT_W = OUT_W - 4;
    localparam logic [2:0]  LOG2_MIN = 3'd3;
    localparam logic [2:0]  LOG2_MAX = 3'(MAX_LOG2);
    localparam logic [2:0]  PREC     = 3'd7;
    localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] OUT_MIN = -OUT_MAX - ACC_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        EMIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t state;

    logic                    mode_q;
    logic [2:0]              lw_q;
    logic [2:0]              lh_q;
    logic signed [MV_W-1:0]  c0x_q, c0y_q, c1x_q, c1y_q, c2x_q, c2y_q;

    logic signed [ACC_W-1:0] step_h_x, step_h_y, step_v_x, step_v_y;
    logic signed [ACC_W-1:0] row_x, row_y, col_x, col_y;

    logic signed [ACC_W-1:0] c0x_e, c0y_e, c1x_e, c1y_e, c2x_e, c2y_e;
    logic signed [ACC_W-1:0] dh_x, dh_y, dv_x, dv_y;
    logic signed [ACC_W-1:0] init_x, init_y;
    logic [2:0]              sh_w, sh_h;

    logic                    size_ok;
    logic [IDX_W-1:0]        last_x, last_y;
    logic [IDX_W-1:0]        nxt_x, nxt_y;
    logic                    row_end;
    logic                    next_last;

    // Round to nearest (ties away from zero) after dropping 7 fraction bits, then saturate.
    function automatic logic signed [OUT_W-1:0] round_clip(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] bias;
        logic signed [ACC_W-1:0] sum;
        logic signed [ACC_W-1:0] q;
        bias = acc[ACC_W-1] ? ACC_W'(63) : ACC_W'(64);
        sum  = acc + bias;
        q    = sum >>> 7;
        if (q > OUT_MAX) begin
            return OUT_W'(OUT_MAX);
        end else if (q < OUT_MIN) begin
            return OUT_W'(OUT_MIN);
        end
        return OUT_W'(q);
    endfunction

    always_comb begin
        size_ok = (log2_w >= LOG2_MIN) && (log2_w <= LOG2_MAX) &&
                  (log2_h >= LOG2_MIN) && (log2_h <= LOG2_MAX);
    end

    // Affine deltas and the accumulator start value (centre of sub-block 0,0).
    always_comb begin
        c0x_e  = ACC_W'(c0x_q);
        c0y_e  = ACC_W'(c0y_q);
        c1x_e  = ACC_W'(c1x_q);
        c1y_e  = ACC_W'(c1y_q);
        c2x_e  = ACC_W'(c2x_q);
        c2y_e  = ACC_W'(c2y_q);
        sh_w   = PREC - lw_q;
        sh_h   = PREC - lh_q;
        dh_x   = (c1x_e - c0x_e) <<< sh_w;
        dh_y   = (c1y_e - c0y_e) <<< sh_w;
        dv_x   = -dh_y;
        dv_y   = dh_x;
        if (mode_q) begin
            dv_x = (c2x_e - c0x_e) <<< sh_h;
            dv_y = (c2y_e - c0y_e) <<< sh_h;
        end
        init_x = (c0x_e <<< 7) + (dh_x <<< 1) + (dv_x <<< 1);
        init_y = (c0y_e <<< 7) + (dh_y <<< 1) + (dv_y <<< 1);
    end

    // Raster position bookkeeping.
    always_comb begin
        last_x    = IDX_W'((32'd1 << (32'(lw_q) - SB_LOG2)) - 32'd1);
        last_y    = IDX_W'((32'd1 << (32'(lh_q) - SB_LOG2)) - 32'd1);
        row_end   = (out_sb_x == last_x);
        nxt_x     = out_sb_x + IDX_W'(1);
        nxt_y     = out_sb_y;
        if (row_end) begin
            nxt_x = '0;
            nxt_y = out_sb_y + IDX_W'(1);
        end
        next_last = (nxt_x == last_x) && (nxt_y == last_y);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            out_sb_x  <= '0;
            out_sb_y  <= '0;
            mode_q    <= 1'b0;
            lw_q      <= LOG2_MIN;
            lh_q      <= LOG2_MIN;
            c0x_q     <= '0;
            c0y_q     <= '0;
            c1x_q     <= '0;
            c1y_q     <= '0;
            c2x_q     <= '0;
            c2y_q     <= '0;
            step_h_x  <= '0;
            step_h_y  <= '0;
            step_v_x  <= '0;
            step_v_y  <= '0;
            row_x     <= '0;
            row_y     <= '0;
            col_x     <= '0;
            col_y     <= '0;
        end else begin
            err  <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (size_ok) begin
                            mode_q <= mode_6param;
                            lw_q   <= log2_w;
                            lh_q   <= log2_h;
                            c0x_q  <= cpmv0_x;
                            c0y_q  <= cpmv0_y;
                            c1x_q  <= cpmv1_x;
                            c1y_q  <= cpmv1_y;
                            c2x_q  <= cpmv2_x;
                            c2y_q  <= cpmv2_y;
                            busy   <= 1'b1;
                            state  <= SETUP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SETUP: begin
                    step_h_x  <= dh_x <<< SB_LOG2;
                    step_h_y  <= dh_y <<< SB_LOG2;
                    step_v_x  <= dv_x <<< SB_LOG2;
                    step_v_y  <= dv_y <<< SB_LOG2;
                    row_x     <= init_x;
                    row_y     <= init_y;
                    col_x     <= init_x;
                    col_y     <= init_y;
                    out_sb_x  <= '0;
                    out_sb_y  <= '0;
                    out_last  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= EMIT;
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            state     <= FIN;
                        end else begin
                            if (row_end) begin
                                row_x <= row_x + step_v_x;
                                row_y <= row_y + step_v_y;
                                col_x <= row_x + step_v_x;
                                col_y <= row_y + step_v_y;
                            end else begin
                                col_x <= col_x + step_h_x;
                                col_y <= col_y + step_h_y;
                            end
                            out_sb_x <= nxt_x;
                            out_sb_y <= nxt_y;
                            out_last <= next_last;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // MV outputs follow the column accumulators directly, so they hold while stalled.
    always_comb begin
        out_mv_x      = round_clip(col_x);
        out_mv_y      = round_clip(col_y);
        out_mv_x_int  = INT_W'(out_mv_x >>> 4);
        out_mv_y_int  = INT_W'(out_mv_y >>> 4);
        out_mv_x_frac = out_mv_x[3:0];
        out_mv_y_frac = out_mv_y[3:0];
    end

endmodule

// File: tb/tb_affine_sb_mv_gen.sv
`timescale 1ns/1ps
// Scoreboard bench for affine_sb_mv_gen: expected sub-block MVs are queued from
// directed constants or an arithmetic reference model and popped by a monitor.
module tb_affine_sb_mv_gen;

    localparam int MV_W     = 18;
    localparam int OUT_W    = 18;
    localparam int MAX_LOG2 = 7;
    localparam int SB_LOG2  = 2;
    localparam int IDX_W    = MAX_LOG2 - SB_LOG2;

    logic                        clk;
    logic                        reset;
    logic                        start;
    logic                        mode_6param;
    logic [2:0]                  log2_w, log2_h;
    logic signed [MV_W-1:0]      cpmv0_x, cpmv0_y, cpmv1_x, cpmv1_y, cpmv2_x, cpmv2_y;
    logic                        out_ready;
    logic                        out_valid;
    logic signed [OUT_W-1:0]     out_mv_x, out_mv_y;
    logic signed [OUT_W-5:0]     out_mv_x_int, out_mv_y_int;
    logic [3:0]                  out_mv_x_frac, out_mv_y_frac;
    logic [IDX_W-1:0]            out_sb_x, out_sb_y;
    logic                        out_last, busy, done, err;

    affine_sb_mv_gen #(
        .MV_W(MV_W), .OUT_W(OUT_W), .MAX_LOG2(MAX_LOG2), .SB_LOG2(SB_LOG2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mode_6param(mode_6param),
        .log2_w(log2_w), .log2_h(log2_h),
        .cpmv0_x(cpmv0_x), .cpmv0_y(cpmv0_y), .cpmv1_x(cpmv1_x), .cpmv1_y(cpmv1_y),
        .cpmv2_x(cpmv2_x), .cpmv2_y(cpmv2_y),
        .out_ready(out_ready), .out_valid(out_valid),
        .out_mv_x(out_mv_x), .out_mv_y(out_mv_y),
        .out_mv_x_int(out_mv_x_int), .out_mv_y_int(out_mv_y_int),
        .out_mv_x_frac(out_mv_x_frac), .out_mv_y_frac(out_mv_y_frac),
        .out_sb_x(out_sb_x), .out_sb_y(out_sb_y), .out_last(out_last),
        .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        longint mx;
        longint my;
        int     sx;
        int     sy;
        bit     last;
    } beat_t;

    beat_t  exp_q[$];
    beat_t  mon_e;
    int     checks = 0;
    int     errors = 0;
    int     hs_count = 0;
    bit     pending_done = 1'b0;
    bit     rand_ready = 1'b0;

    function automatic longint rnd_clip(input longint acc);
        longint q;
        if (acc >= 0) q = (acc + 64) / 128;
        else          q = -((-acc + 64) / 128);
        if (q > 131071)  q = 131071;
        if (q < -131072) q = -131072;
        return q;
    endfunction

    function automatic longint floor16(input longint v);
        return (v >= 0) ? v / 16 : -((-v + 15) / 16);
    endfunction

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push_beat(input longint mx, input longint my, input int sx, input int sy, input bit last);
        beat_t b;
        b.mx = mx; b.my = my; b.sx = sx; b.sy = sy; b.last = last;
        exp_q.push_back(b);
    endtask

    // Reference: evaluate the affine field directly at each sub-block centre.
    task automatic model_cu(input bit mode, input int lw, input int lh,
                            input longint c0x, input longint c0y, input longint c1x,
                            input longint c1y, input longint c2x, input longint c2y);
        longint dhx, dhy, dvx, dvy, px, py;
        int nx, ny;
        dhx = (c1x - c0x) * longint'(1 << (7 - lw));
        dhy = (c1y - c0y) * longint'(1 << (7 - lw));
        if (mode) begin
            dvx = (c2x - c0x) * longint'(1 << (7 - lh));
            dvy = (c2y - c0y) * longint'(1 << (7 - lh));
        end else begin
            dvx = -dhy;
            dvy = dhx;
        end
        nx = (1 << lw) / 4;
        ny = (1 << lh) / 4;
        for (int sy = 0; sy < ny; sy++) begin
            for (int sx = 0; sx < nx; sx++) begin
                px = longint'(4 * sx + 2);
                py = longint'(4 * sy + 2);
                push_beat(rnd_clip(c0x * 128 + dhx * px + dvx * py),
                          rnd_clip(c0y * 128 + dhy * px + dvy * py),
                          sx, sy, (sx == nx - 1) && (sy == ny - 1));
            end
        end
    endtask

    // Called at posedge+1; pulses start, scrambles inputs, checks the 2-cycle latency.
    task automatic start_cu(input bit mode, input int lw, input int lh,
                            input longint c0x, input longint c0y, input longint c1x,
                            input longint c1y, input longint c2x, input longint c2y);
        start       = 1'b1;
        mode_6param = mode;
        log2_w      = 3'(lw);
        log2_h      = 3'(lh);
        cpmv0_x = MV_W'(c0x); cpmv0_y = MV_W'(c0y);
        cpmv1_x = MV_W'(c1x); cpmv1_y = MV_W'(c1y);
        cpmv2_x = MV_W'(c2x); cpmv2_y = MV_W'(c2y);
        @(posedge clk); #1;
        start       = 1'b0;
        mode_6param = 1'($urandom);
        log2_w      = 3'($urandom);
        log2_h      = 3'($urandom);
        cpmv0_x = MV_W'($urandom); cpmv0_y = MV_W'($urandom);
        cpmv1_x = MV_W'($urandom); cpmv1_y = MV_W'($urandom);
        cpmv2_x = MV_W'($urandom); cpmv2_y = MV_W'($urandom);
        check("setup_valid", longint'(out_valid), 0);
        check("setup_busy", longint'(busy), 1);
        @(posedge clk); #1;
        check("first_valid", longint'(out_valid), 1);
    endtask

    task automatic wait_cu(input int limit);
        int n = 0;
        while ((exp_q.size() != 0 || pending_done || busy) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= limit) begin
            checks++;
            errors++;
            $display("FAIL cu_timeout: %0d beats still pending after %0d cycles", exp_q.size(), limit);
            exp_q.delete();
            pending_done = 1'b0;
        end
    endtask

    task automatic wait_hs(input int target);
        int n = 0;
        while (hs_count < target && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL hs_timeout: handshakes %0d want %0d", hs_count, target);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_valid"}, longint'(out_valid), 0);
        check({tag, "_busy"}, longint'(busy), 0);
        check({tag, "_done"}, longint'(done), 0);
        check({tag, "_err"}, longint'(err), 0);
        check({tag, "_last"}, longint'(out_last), 0);
        check({tag, "_mv"}, longint'({out_mv_x, out_mv_y}), 0);
        check({tag, "_intfrac"}, longint'({out_mv_x_int, out_mv_y_int, out_mv_x_frac, out_mv_y_frac}), 0);
        check({tag, "_sb"}, longint'({out_sb_x, out_sb_y}), 0);
    endtask

    // Random downstream readiness when enabled.
    always @(posedge clk) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 9) < 7);
    end

    // Monitor: compare every presented beat with the queue head; pop on handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (pending_done || done) begin
                checks++;
                if (done !== pending_done) begin
                    errors++;
                    $display("FAIL done_pulse: got %0d want %0d", done, pending_done);
                end
            end
            pending_done = 1'b0;
            if (out_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got mv=(%0d,%0d) sb=(%0d,%0d) want no beat",
                             out_mv_x, out_mv_y, out_sb_x, out_sb_y);
                end else begin
                    mon_e = exp_q[0];
                    if (longint'(out_mv_x) != mon_e.mx || longint'(out_mv_y) != mon_e.my ||
                        longint'(out_mv_x_int) != floor16(mon_e.mx) ||
                        longint'(out_mv_y_int) != floor16(mon_e.my) ||
                        longint'(out_mv_x_frac) != mon_e.mx - 16 * floor16(mon_e.mx) ||
                        longint'(out_mv_y_frac) != mon_e.my - 16 * floor16(mon_e.my) ||
                        int'(out_sb_x) != mon_e.sx || int'(out_sb_y) != mon_e.sy ||
                        out_last != mon_e.last) begin
                        errors++;
                        $display("FAIL beat: got mv=(%0d,%0d) int=(%0d,%0d) frac=(%0d,%0d) sb=(%0d,%0d) last=%0d want mv=(%0d,%0d) int=(%0d,%0d) frac=(%0d,%0d) sb=(%0d,%0d) last=%0d",
                                 out_mv_x, out_mv_y, out_mv_x_int, out_mv_y_int, out_mv_x_frac, out_mv_y_frac,
                                 out_sb_x, out_sb_y, out_last,
                                 mon_e.mx, mon_e.my, floor16(mon_e.mx), floor16(mon_e.my),
                                 mon_e.mx - 16 * floor16(mon_e.mx), mon_e.my - 16 * floor16(mon_e.my),
                                 mon_e.sx, mon_e.sy, mon_e.last);
                    end
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        hs_count++;
                        if (mon_e.last) pending_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h0;
        int mode, lw, lh, rng;
        longint c[6];
        reset = 1'b1;
        start = 1'b0;
        mode_6param = 1'b0;
        log2_w = 3'd3;
        log2_h = 3'd3;
        cpmv0_x = '0; cpmv0_y = '0; cpmv1_x = '0; cpmv1_y = '0; cpmv2_x = '0; cpmv2_y = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Translational 8x8
        for (int i = 0; i < 4; i++) push_beat(5, -3, i % 2, i / 2, i == 3);
        start_cu(0, 3, 3, 5, -3, 5, -3, 5, -3);
        wait_cu(100);

        // 4-parameter zoom 8x8
        push_beat(4, 4, 0, 0, 0);
        push_beat(12, 4, 1, 0, 0);
        push_beat(4, 12, 0, 1, 0);
        push_beat(12, 12, 1, 1, 1);
        start_cu(0, 3, 3, 0, 0, 16, 0, 0, 0);
        wait_cu(100);

        // 6-parameter 8x16 vertical gradient
        for (int sy = 0; sy < 4; sy++)
            for (int sx = 0; sx < 2; sx++)
                push_beat(longint'(8 * sy + 4), 0, sx, sy, (sx == 1) && (sy == 3));
        start_cu(1, 3, 4, 0, 0, 0, 0, 32, 0);
        wait_cu(100);

        // Saturation
        push_beat(-1, 0, 0, 0, 0);
        push_beat(131071, 0, 1, 0, 0);
        push_beat(131071, 0, 0, 1, 0);
        push_beat(131071, 0, 1, 1, 1);
        start_cu(1, 3, 3, -131072, 0, 131071, 0, 131071, 0);
        wait_cu(100);

        // Backpressure: stall beat 5 of a 16x16 CU for 3 cycles
        h0 = hs_count;
        model_cu(0, 4, 4, 7, -9, 7, -9, 0, 0);
        start_cu(0, 4, 4, 7, -9, 7, -9, 0, 0);
        wait_hs(h0 + 4);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stall_hs", longint'(hs_count - h0), 4);
        out_ready = 1'b1;
        wait_cu(200);
        check("stall_beats", longint'(hs_count - h0), 16);

        // Illegal sizes
        start = 1'b1; log2_w = 3'd2; log2_h = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_w_pulse", longint'(err), 1);
        check("err_w_busy", longint'(busy), 0);
        @(posedge clk); #1;
        check("err_w_clear", longint'(err), 0);
        check("err_w_novalid", longint'(out_valid), 0);
        start = 1'b1; log2_w = 3'd5; log2_h = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("err_h_pulse", longint'(err), 1);
        repeat (3) @(posedge clk);
        #1;
        check("err_h_novalid", longint'(out_valid), 0);

        // START while busy is ignored
        model_cu(0, 4, 4, 100, -50, 140, -20, 0, 0);
        start_cu(0, 4, 4, 100, -50, 140, -20, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        start = 1'b1; mode_6param = 1'b1; log2_w = 3'd3; log2_h = 3'd3;
        cpmv0_x = MV_W'(999); cpmv1_x = MV_W'(-999);
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_start_busy", longint'(busy), 1);
        wait_cu(200);
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a 16x16 CU
        h0 = hs_count;
        model_cu(0, 4, 4, 33, 17, 33, 17, 0, 0);
        start_cu(0, 4, 4, 33, 17, 33, 17, 0, 0);
        wait_hs(h0 + 2);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        pending_done = 1'b0;
        check_idle_outputs("midreset");
        repeat (4) @(posedge clk);
        #1;
        check("midreset_quiet", longint'({out_valid, busy, done}), 0);

        // Randomized back-to-back CUs with random backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            mode = int'($urandom_range(0, 1));
            lw   = int'($urandom_range(3, 7));
            lh   = int'($urandom_range(3, 7));
            rng  = (n % 2 == 0) ? 64 : 131072;
            for (int k = 0; k < 6; k++)
                c[k] = longint'(int'($urandom_range(0, 2 * rng - 1)) - rng);
            model_cu(mode[0], lw, lh, c[0], c[1], c[2], c[3], c[4], c[5]);
            start_cu(mode[0], lw, lh, c[0], c[1], c[2], c[3], c[4], c[5]);
            wait_cu(6000);
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
